// File: rtl/arb4_priority_sched.sv
// arb4_priority_sched: four-client arbiter with fixed or round-robin
// priority, grant hold while the owner keeps requesting, bounded by MAX_HOLD.
// Ports: clk, rst (async, active-high), rr_mode, req[3:0] in;
//        gnt[3:0] (one-hot), gnt_id[1:0], gnt_valid, preempt out (all registered).
module arb4_priority_sched #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rr_mode,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       last, last_nxt;
    logic [3:0]       gnt_nxt;
    logic [1:0]       gnt_id_nxt;
    logic             gnt_valid_nxt;
    logic             preempt_nxt;

    logic [3:0] cand;
    logic       win_ok;
    logic [1:0] win_id;
    logic [1:0] rr_start;
    logic [1:0] rr_idx;
    logic       owner_req;
    logic       expired;
    logic       do_grant;

    assign owner_req = req[gnt_id];
    assign expired   = (cnt == CNT_W'(MAX_HOLD));

    // While the owner still requests, it is excluded from the candidates;
    // the result is only used on expiry in that situation.
    always_comb begin
        cand = req;
        if (state == GRANT && owner_req)
            cand[gnt_id] = 1'b0;
    end

    always_comb begin
        win_ok   = |cand;
        win_id   = 2'd0;
        rr_start = last + 2'd1;
        rr_idx   = 2'd0;
        if (!rr_mode) begin
            for (int i = 0; i < 4; i++)
                if (cand[i]) win_id = 2'(i);
        end else begin
            // Descending offsets: the smallest offset from rr_start wins.
            for (int i = 3; i >= 0; i--) begin
                rr_idx = rr_start + 2'(i);
                if (cand[rr_idx]) win_id = rr_idx;
            end
        end
    end

    always_comb begin
        do_grant = 1'b0;
        unique case (state)
            IDLE:  do_grant = win_ok;
            GRANT: do_grant = (!owner_req || expired) && win_ok;
            default: do_grant = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_ok) state_nxt = GRANT;
            GRANT:   if (!owner_req && !win_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        preempt_nxt   = 1'b0;
        last_nxt      = last;
        cnt_nxt       = cnt;
        if (do_grant) begin
            gnt_nxt       = 4'b0001 << win_id;
            gnt_id_nxt    = win_id;
            gnt_valid_nxt = 1'b1;
            last_nxt      = win_id;
            cnt_nxt       = CNT_W'(1);
            preempt_nxt   = (state == GRANT) && owner_req;
        end else if (state == GRANT) begin
            if (!owner_req) begin
                gnt_nxt       = 4'b0000;
                gnt_valid_nxt = 1'b0;
                cnt_nxt       = '0;
            end else if (expired) begin
                cnt_nxt = CNT_W'(1);
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            last      <= 2'd3;
            cnt       <= '0;
        end else begin
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            preempt   <= preempt_nxt;
            last      <= last_nxt;
            cnt       <= cnt_nxt;
        end
    end

endmodule

// File: doc/arb4_priority_sched.md
Name: arb4_priority_sched

Overview:
- Sequential 4-requester arbiter that shares one resource among four clients.
- Wraps the team's 4:2 priority-encode function in a grant state machine.
- Two arbitration modes: fixed priority (req[3] highest, matching the priority encoder) or round-robin.
- Grants are held while the owner keeps requesting, bounded by a hold-time limit. Sits between client request lines and the shared datapath select.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others wait; legal range 2..255.
- CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- rr_mode  input  1  0 = fixed priority (req[3] > req[2] > req[1] > req[0]); 1 = round-robin.
- req  input  4  request lines, level-sensitive, one per client.
- gnt  output  4  one-hot grant, registered.
- gnt_id  output  2  binary index of the granted client, registered.
- gnt_valid  output  1  1 when gnt is non-zero.
- preempt  output  1  one-cycle pulse: the current grant was issued because of a hold-limit expiry.

Behaviour:
- Reset (asynchronous on rst=1):
  - gnt=0, gnt_id=0, gnt_valid=0, preempt=0.
  - State=IDLE, hold counter=0, round-robin pointer last=3, so the first RR search starts at index 0.
- States: IDLE, GRANT. All outputs are registered; no combinational path from req to outputs.
- Arbitration function, evaluated on a candidate vector c:
  - Fixed mode: highest set index wins.
  - RR mode: first set index searching upward from (last+1) mod 4, wrapping.
  - c==0 means no winner.
- IDLE:
  - On an edge with req!=0: arbitrate on c=req.
  - Load gnt/gnt_id/gnt_valid=1, last=winner, counter=1, go to GRANT.
  - Grant latency is 1 clock from req sampled high.
- GRANT, owner o, at each edge, in this precedence:
  1. req[o]=0 (release): arbitrate on c=req.
     - If a winner exists, grant it on this same edge: back-to-back, no idle gap; counter=1, last=winner.
     - Otherwise clear gnt/gnt_valid, go to IDLE. gnt_id holds its last value.
  2. req[o]=1 and counter==MAX_HOLD (expiry): arbitrate on c=req with bit o masked.
     - If a winner exists: switch grant to it, counter=1, last=winner, preempt=1 for one cycle.
     - Otherwise o keeps the grant, counter=1, preempt=0.
  3. Otherwise: keep the grant and increment the counter.
     - The counter never exceeds MAX_HOLD.
     - The owner therefore holds at most MAX_HOLD consecutive cycles while contended.
- preempt is 0 on every edge except case 2 with a new winner.
- rr_mode is sampled only at arbitration edges. Changing it mid-grant does not affect the current owner.
- last updates only when a new grant is issued, in both modes. This keeps RR fair after a mode switch.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_id == index of gnt whenever gnt_valid=1.
- Reset asserted mid-grant forces all outputs to the reset values immediately, without waiting for a clock edge.
- After rst deasserts, the first grant follows the IDLE rules with last=3.

Test Plan:
1. Reset and fixed-priority order.
   - Stimulus: rst=1, then 0, rr_mode=0, req=4'b1111 for 3 cycles, then req=4'b0111.
   - Required: gnt=0 during reset; gnt=4'b1000, gnt_id=3 one edge after req; after req[3] drops, gnt=4'b0100, gnt_id=2 on the same edge (no gap).
2. Round-robin rotation.
   - Stimulus: rr_mode=1, each owner drops its request one cycle after being granted and re-raises it the next cycle, so req is effectively 4'b1111.
   - Required: grants rotate 0,1,2,3,0 with gnt_valid=1 continuously.
3. Hold-limit preemption.
   - Stimulus: MAX_HOLD=8, rr_mode=1, req=4'b0001 granted, then req=4'b0011 held steady.
   - Required: client 0 holds exactly 8 cycles, then gnt=4'b0010 with a one-cycle preempt=1.
   - Required: with only req=4'b0001, client 0 keeps the grant indefinitely and preempt stays 0.
4. Release with no other requester.
   - Stimulus: req=4'b0100 for 2 cycles, then 4'b0000.
   - Required: gnt=4'b0100 then gnt=0, gnt_valid=0, gnt_id stays 2, state returns to IDLE; a new req=4'b0001 is granted one edge later.
5. Asynchronous reset mid-grant.
   - Stimulus: assert rst between clock edges while gnt=4'b0010.
   - Required: gnt=0, gnt_valid=0, preempt=0 without waiting for an edge.
   - Required: after release with rr_mode=1 and req=4'b1111, the first grant goes to client 0.
6. Mode switch mid-grant.
   - Stimulus: rr_mode changes 0->1 while client 3 holds the grant and req=4'b1011.
   - Required: client 3 keeps the grant until release or expiry; the next grant goes to client 0 (search from last+1=0).
